// File: rtl/baudgen_pkg.sv
// rtl/baudgen_pkg.sv - shared divisor type, clamp limit and 25 MHz x16 baud presets
package baudgen_pkg;

  localparam int MIN_DIV_INT = 2;

  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } divisor_t;

  // 25 MHz / (baud * 16), fractional part in 1/16 steps
  localparam divisor_t DIV_19200  = '{div_int: 16'd81, div_frac: 4'd6};
  localparam divisor_t DIV_38400  = '{div_int: 16'd40, div_frac: 4'd11};
  localparam divisor_t DIV_57600  = '{div_int: 16'd27, div_frac: 4'd2};
  localparam divisor_t DIV_115200 = '{div_int: 16'd13, div_frac: 4'd9};

endpackage

// File: rtl/baudgen_frac.sv
// rtl/baudgen_frac.sv - fractional baud generator producing oversample and bit strobes
module baudgen_frac
  import baudgen_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OSR          = 16,
  parameter int RST_DIV_INT  = 13,
  parameter int RST_DIV_FRAC = 9
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              div_err
);

  localparam int OSC_W = $clog2(OSR);
  localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(MIN_DIV_INT);
  localparam logic [DIV_W-1:0]  RST_INT  = (RST_DIV_INT < MIN_DIV_INT) ? MIN_INT : DIV_W'(RST_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV_FRAC);
  localparam logic [OSC_W-1:0]  OSC_LAST = OSC_W'(OSR - 1);

  logic [DIV_W-1:0]  cnt, active_int, pend_int, load_int, next_int, reload;
  logic [FRAC_W-1:0] acc, active_frac, pend_frac, next_frac;
  logic [FRAC_W:0]   acc_sum;
  logic [OSC_W-1:0]  os_cnt;
  logic              pend_valid, pend_err, load_err, next_err, tick_now;

  // next_* is the divisor that governs the period starting at the next reload
  always_comb begin
    load_err  = div_int < MIN_INT;
    load_int  = load_err ? MIN_INT : div_int;
    next_int  = pend_valid ? pend_int : active_int;
    next_frac = pend_valid ? pend_frac : active_frac;
    next_err  = pend_valid ? pend_err : div_err;
    acc_sum   = {1'b0, acc} + {1'b0, active_frac};
    reload    = next_int - DIV_W'(1) + DIV_W'(acc_sum[FRAC_W]);
    tick_now  = (cnt == '0);
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      active_int  <= RST_INT;
      active_frac <= RST_FRAC;
      pend_int    <= RST_INT;
      pend_frac   <= RST_FRAC;
      pend_err    <= 1'b0;
      pend_valid  <= 1'b0;
      div_err     <= 1'b0;
      cnt         <= RST_INT - DIV_W'(1);
      acc         <= '0;
      os_cnt      <= '0;
      os_tick     <= 1'b0;
      baud_tick   <= 1'b0;
    end else if (restart) begin
      active_int  <= next_int;
      active_frac <= next_frac;
      div_err     <= next_err;
      pend_valid  <= 1'b0;
      cnt         <= next_int - DIV_W'(1);
      acc         <= '0;
      os_cnt      <= '0;
      os_tick     <= 1'b0;
      baud_tick   <= 1'b0;
    end else if (en) begin
      os_tick   <= tick_now;
      baud_tick <= tick_now && (os_cnt == OSC_LAST);
      if (tick_now) begin
        cnt         <= reload;
        acc         <= acc_sum[FRAC_W-1:0];
        os_cnt      <= (os_cnt == OSC_LAST) ? '0 : os_cnt + OSC_W'(1);
        active_int  <= next_int;
        active_frac <= next_frac;
        div_err     <= next_err;
        pend_valid  <= 1'b0;
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
      // a load on a tick edge lands after the old pending value was consumed
      if (div_load) begin
        pend_int   <= load_int;
        pend_frac  <= div_frac;
        pend_err   <= load_err;
        pend_valid <= 1'b1;
      end
    end else begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      if (div_load) begin
        active_int  <= load_int;
        active_frac <= div_frac;
        div_err     <= load_err;
        pend_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baudgen_frac.sv
// tb/tb_baudgen_frac.sv - bench for baudgen_frac against a period-level reference model
module tb_baudgen_frac;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        os_tick, baud_tick, div_err;

  baudgen_frac #(
    .DIV_W(16), .FRAC_W(4), .OSR(16), .RST_DIV_INT(13), .RST_DIV_FRAC(9)
  ) dut (
    .clkin(clkin), .rst(rst), .en(en), .restart(restart),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .os_tick(os_tick), .baud_tick(baud_tick), .div_err(div_err)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int tq[$];
  int bq[$];

  // reference model: divisor values, elapsed cycles in current period, period length
  int m_int, m_frac, m_err, p_int, p_frac, p_err, p_valid;
  int m_elapsed, m_period, m_acc, m_osc, m_tick, m_baud;

  function automatic int clampi(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_int = clampi(13); m_frac = 9; m_err = 0;
    p_int = m_int; p_frac = m_frac; p_err = 0; p_valid = 0;
    m_elapsed = 0; m_period = m_int; m_acc = 0; m_osc = 0;
    m_tick = 0; m_baud = 0;
  endtask

  task automatic apply_pending();
    if (p_valid != 0) begin
      m_int = p_int; m_frac = p_frac; m_err = p_err;
    end
    p_valid = 0;
  endtask

  task automatic model_step();
    int sum;
    if (rst) begin
      model_reset();
      return;
    end
    m_tick = 0; m_baud = 0;
    if (restart) begin
      apply_pending();
      m_elapsed = 0; m_period = m_int; m_acc = 0; m_osc = 0;
    end else if (en) begin
      m_elapsed++;
      if (m_elapsed >= m_period) begin
        m_tick = 1;
        m_baud = (m_osc == 15) ? 1 : 0;
        m_osc = (m_osc + 1) % 16;
        sum = m_acc + m_frac;
        m_acc = sum % 16;
        apply_pending();
        m_period = m_int + sum / 16;
        m_elapsed = 0;
      end
      if (div_load) begin
        p_int = clampi(int'(div_int)); p_frac = int'(div_frac);
        p_err = (div_int < 2) ? 1 : 0; p_valid = 1;
      end
    end else if (div_load) begin
      m_int = clampi(int'(div_int)); m_frac = int'(div_frac);
      m_err = (div_int < 2) ? 1 : 0; p_valid = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clkin);
    cyc++;
    model_step();
    #6;
  endtask

  task automatic wait_ticks(input int n, input int budget, input string name);
    int k = 0;
    while (tq.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk({name, "_reached"}, (tq.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic load_idle(input int di, input int df);
    en = 1'b0; div_int = 16'(di); div_frac = 4'(df); div_load = 1'b1;
    cycle();
    div_load = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    cyc = 0;
    tq.delete();
    bq.delete();
  endtask

  always @(negedge clkin) begin
    chk("os_tick", int'(os_tick), m_tick);
    chk("baud_tick", int'(baud_tick), m_baud);
    chk("div_err", int'(div_err), m_err);
    if (os_tick) tq.push_back(cyc);
    if (baud_tick) bq.push_back(cyc);
  end

  initial begin
    int bad;
    model_reset();
    repeat (3) cycle();
    chk("rst_os_tick", int'(os_tick), 0);
    chk("rst_baud_tick", int'(baud_tick), 0);
    chk("rst_div_err", int'(div_err), 0);

    // reset default 13.5625
    rst = 1'b0; en = 1'b1; cyc = 0; tq.delete(); bq.delete();
    wait_ticks(33, 800, "dflt");
    chk("dflt_first", tq[0], 13);
    chk("dflt_span16", tq[16] - tq[0], 217);
    chk("dflt_span16b", tq[17] - tq[1], 217);
    chk("dflt_baud_first", bq[0], tq[15]);
    chk("dflt_baud_period", bq[1] - bq[0], 217);

    // 4.0 with restart
    load_idle(4, 0);
    do_restart();
    en = 1'b1;
    wait_ticks(33, 300, "div4");
    chk("div4_first", tq[0], 4);
    bad = 0;
    for (int i = 1; i < tq.size(); i++) if (tq[i] - tq[i-1] != 4) bad++;
    chk("div4_gaps", bad, 0);
    chk("div4_baud_first", bq[0], 64);
    chk("div4_baud_period", bq[1] - bq[0], 64);

    // load 8.0 mid-period while running
    tq.delete();
    wait_ticks(1, 20, "ld8_sync");
    div_int = 16'd8; div_frac = 4'd0; div_load = 1'b1;
    cycle();
    div_load = 1'b0;
    wait_ticks(3, 40, "ld8");
    chk("ld8_cur_period", tq[1] - tq[0], 4);
    chk("ld8_next_period", tq[2] - tq[1], 8);

    // 13.5
    load_idle(13, 8);
    do_restart();
    en = 1'b1;
    wait_ticks(17, 300, "d13_5");
    chk("d13_5_first", tq[0], 13);
    chk("d13_5_gap1", tq[1] - tq[0], 13);
    chk("d13_5_gap2", tq[2] - tq[1], 14);
    chk("d13_5_span16", tq[16] - tq[0], 216);

    // clamp and error flag
    load_idle(1, 0);
    chk("clamp_err_set", int'(div_err), 1);
    do_restart();
    en = 1'b1;
    wait_ticks(3, 20, "clamp");
    chk("clamp_first", tq[0], 2);
    chk("clamp_period", tq[1] - tq[0], 2);
    load_idle(5, 0);
    chk("clamp_err_clr", int'(div_err), 0);
    do_restart();
    en = 1'b1;
    wait_ticks(2, 30, "div5");
    chk("div5_first", tq[0], 5);
    chk("div5_period", tq[1] - tq[0], 5);

    // enable low for 7 cycles mid-period
    tq.delete();
    wait_ticks(1, 20, "hold_sync");
    cycle(); cycle();
    en = 1'b0;
    repeat (7) cycle();
    en = 1'b1;
    wait_ticks(2, 40, "hold");
    chk("hold_gap", tq[1] - tq[0], 12);

    do_restart();
    wait_ticks(1, 20, "rstrt");
    chk("rstrt_first", tq[0], 5);

    // async reset while os_tick is high
    tq.delete();
    wait_ticks(1, 20, "arst_sync");
    chk("tick_before_rst", int'(os_tick), 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_os_tick", int'(os_tick), 0);
    chk("arst_baud_tick", int'(baud_tick), 0);
    repeat (3) cycle();
    rst = 1'b0; cyc = 0; tq.delete();
    wait_ticks(1, 30, "post_rst");
    chk("post_rst_first", tq[0], 13);

    // randomized traffic, compared every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 39) == 0);
      div_int = 16'($urandom_range(0, 12));
      div_frac = 4'($urandom_range(0, 15));
      restart = ($urandom_range(0, 249) == 0);
      cycle();
    end
    div_load = 1'b0; restart = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/baudgen_frac.md
BAUDGEN_FRAC -- requirements
Module: baudgen_frac

Interface
REQ-001 Parameters SHALL be: DIV_W, default 16, integer divisor width.
REQ-002 FRAC_W, default 4, fractional divisor width in 1/2^FRAC_W steps.
REQ-003 OSR, default 16, oversample ticks per bit, legal range 2..256.
REQ-004 RST_DIV_INT, default 13, integer divisor after reset; RST_DIV_FRAC, default 9, fractional divisor after reset (13.5625 gives 115200 baud x16 at 25 MHz).
REQ-005 Ports SHALL be: clkin  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  count enable; when low, all state holds.
REQ-008 restart  input  1  synchronous phase restart pulse.
REQ-009 div_int  input  DIV_W  requested integer divisor, in clkin cycles per os_tick.
REQ-010 div_frac  input  FRAC_W  requested fractional divisor.
REQ-011 div_load  input  1  one-cycle pulse that captures div_int and div_frac into the pending register.
REQ-012 os_tick  output  1  one-cycle oversample strobe.
REQ-013 baud_tick  output  1  one-cycle bit strobe, every OSR-th os_tick.
REQ-014 div_err  output  1  active divisor was clamped.

Function
REQ-015 The effective period SHALL be D = div_int + div_frac/2^FRAC_W clkin cycles per os_tick, averaged over 2^FRAC_W ticks.
REQ-016 Divide counter cnt: on each enabled cycle, decrement; os_tick asserts on the next edge when cnt==0, and cnt reloads with active_int-1+carry.
REQ-017 Fractional accumulator acc (FRAC_W bits): on each os_tick, {carry,acc} <= acc + active_frac; the carry SHALL lengthen the next period by exactly one cycle; wrap-around is modulo 2^FRAC_W.
REQ-018 os_cnt counts os_ticks 0..OSR-1 and wraps; baud_tick SHALL assert coincident with the os_tick on which os_cnt==OSR-1.
REQ-019 os_tick and baud_tick SHALL be registered, high for exactly one cycle, and never asserted while en is low.
REQ-020 The first os_tick SHALL assert on the active_int-th enabled rising edge after reset release or restart.
REQ-021 div_load with en high SHALL hold the value in the pending register until the next os_tick, then copy it to the active divisor; the period already in progress is unchanged.
REQ-022 div_load with en low SHALL update the active divisor on the next edge.
REQ-023 A later div_load before application SHALL overwrite the pending value; the last value written wins.
REQ-024 If a loaded div_int < 2, the active integer divisor SHALL be 2 and div_err SHALL be set; the next valid load clears div_err.
REQ-025 restart SHALL apply any pending divisor immediately, reload cnt, clear acc and os_cnt, and suppress ticks in that cycle; restart has priority over div_load and en.
REQ-026 While en is low, cnt, acc and os_cnt SHALL hold; counting resumes with no lost or extra cycle.

Reset
REQ-027 On rst, active and pending divisors SHALL take RST_DIV_INT/RST_DIV_FRAC (clamped per REQ-024).
REQ-028 On rst, cnt SHALL be active_int-1, acc 0, and os_cnt 0.
REQ-029 On rst, os_tick, baud_tick and div_err SHALL be 0.
REQ-030 Reset asserted mid-period SHALL abort the period immediately; no tick may assert during reset.

Structure
REQ-031 Package baudgen_pkg SHALL hold the 25 MHz preset divisor constants (19200/38400/57600/115200 x16) and a typedef for the {int,frac} divisor struct.
REQ-032 The design SHALL be a single module with no sub-modules.
REQ-033 The target implementation size is 120-400 lines of RTL.

Verification
REQ-034 div=4.0, OSR=16, en=1 -> os_tick every 4 cycles; baud_tick every 64 cycles, coincident with every 16th os_tick.
REQ-035 div=13.5 (frac=8) -> os_tick periods alternate 13,14; 16 os_ticks span exactly 216 cycles.
REQ-036 Reset defaults (13.5625) -> 16 os_ticks span exactly 217 cycles; baud_tick period averages 217 cycles.
REQ-037 div_load 8.0 mid-period while running at 4.0 -> current period stays 4; the following period is 8.
REQ-038 div_load div_int=1 -> div_err=1 and period=2; then div_load 5 -> div_err=0 and period=5.
REQ-039 en low for 7 cycles mid-period, then restart, then rst mid-period -> state holds while en is low; restart gives first os_tick after active_int cycles; rst forces all outputs to 0 with immediate effect.
